// File: rtl/note_player.sv
// Note sequencer for the harmonics engine: accepts note requests, converts the
// note code to a phase step, and holds engine controls steady for the note plus a muted release gap.
module note_player #(
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        beat,
    input  logic        stop,
    input  logic        note_valid,
    input  logic [5:0]  note,
    input  logic [5:0]  duration,
    input  logic [1:0]  note_instrument,
    output logic        note_ready,
    output logic        note_finished,
    output logic        busy,
    output logic        h_play_enable,
    output logic [19:0] h_step_size,
    output logic [1:0]  h_instrument,
    output logic        h_note_done
);

    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

    localparam logic [7:0] REL_LAST = 8'(RELEASE_CYCLES - 1);

    state_t      state, state_next;
    logic [5:0]  beat_cnt, beat_cnt_next, beat_inc;
    logic [7:0]  rel_cnt, rel_cnt_next;
    logic [5:0]  dur_q, dur_next;
    logic        rest_q, rest_next;
    logic [19:0] step_next;
    logic [1:0]  inst_next;
    logic        finish_next;
    logic        accept;

    // Octave 5 (C6 up) uses the BASE table unshifted; each lower octave halves it.
    function automatic logic [19:0] note_step(input logic [5:0] n);
        logic [5:0]  k;
        logic [2:0]  octave;
        logic [3:0]  semitone;
        logic [19:0] base;
        k        = n - 6'd1;
        octave   = 3'(k / 6'd12);
        semitone = 4'(k % 6'd12);
        case (semitone)
            4'd0:    base = 20'd22861;
            4'd1:    base = 20'd24220;
            4'd2:    base = 20'd25661;
            4'd3:    base = 20'd27187;
            4'd4:    base = 20'd28803;
            4'd5:    base = 20'd30516;
            4'd6:    base = 20'd32331;
            4'd7:    base = 20'd34253;
            4'd8:    base = 20'd36290;
            4'd9:    base = 20'd38448;
            4'd10:   base = 20'd40734;
            default: base = 20'd43155;
        endcase
        if (n == 6'd0) return '0;
        return base >> (3'd5 - octave);
    endfunction

    assign note_ready = (state == IDLE) && play;
    assign accept     = note_valid && note_ready;
    assign beat_inc   = beat_cnt + 6'd1;

    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        rel_cnt_next  = rel_cnt;
        dur_next      = dur_q;
        rest_next     = rest_q;
        step_next     = h_step_size;
        inst_next     = h_instrument;
        finish_next   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    dur_next      = (duration == 6'd0) ? 6'd1 : duration;
                    rest_next     = (note == 6'd0);
                    step_next     = note_step(note);
                    inst_next     = note_instrument;
                    beat_cnt_next = '0;
                    state_next    = PLAY;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_next   = RELEASE;
                    rel_cnt_next = '0;
                end else if (beat && play) begin
                    beat_cnt_next = beat_inc;
                    if (beat_inc == dur_q) begin
                        state_next   = RELEASE;
                        rel_cnt_next = '0;
                    end
                end
            end
            RELEASE: begin
                if (rel_cnt == REL_LAST) begin
                    state_next  = IDLE;
                    finish_next = 1'b1;
                end else begin
                    rel_cnt_next = rel_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: engine controls are registered from the next-state values, so they
    // switch on the same edge as the state and never glitch mid-note.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            rel_cnt       <= '0;
            dur_q         <= 6'd1;
            rest_q        <= 1'b0;
            busy          <= 1'b0;
            note_finished <= 1'b0;
            h_play_enable <= 1'b0;
            h_note_done   <= 1'b1;
            h_step_size   <= '0;
            h_instrument  <= '0;
        end else begin
            state         <= state_next;
            beat_cnt      <= beat_cnt_next;
            rel_cnt       <= rel_cnt_next;
            dur_q         <= dur_next;
            rest_q        <= rest_next;
            busy          <= (state_next != IDLE);
            note_finished <= finish_next;
            h_play_enable <= (state_next != IDLE) && play;
            h_note_done   <= !((state_next == PLAY) && !rest_next);
            h_step_size   <= (state_next == IDLE) ? '0 : step_next;
            h_instrument  <= inst_next;
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Randomised and directed bench for note_player, checked every cycle against a
// countdown-style behavioural model of a note's life (beats left, release cycles left).
module tb_note_player;

    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        play = 1'b0;
    logic        beat = 1'b0;
    logic        stop = 1'b0;
    logic        note_valid = 1'b0;
    logic [5:0]  note = '0;
    logic [5:0]  duration = '0;
    logic [1:0]  note_instrument = '0;
    logic        note_ready, note_finished, busy, h_play_enable, h_note_done;
    logic [19:0] h_step_size;
    logic [1:0]  h_instrument;

    int checks = 0;
    int errors = 0;
    int fin_seen = 0;
    bit cmp_en = 0;
    bit rand_mode = 0;
    bit beat_auto = 1;
    int beat_period = 4;
    int beat_ctr = 0;

    // model state
    bit      m_playing = 0;
    int      m_beats_left = 0;
    int      m_rel_left = 0;
    bit      m_rest = 0;
    int      m_step = 0;
    int      m_inst = 0;
    bit      e_fin = 0;
    bit      e_play_en = 0;

    int unsigned base_tab[12] = '{22861, 24220, 25661, 27187, 28803, 30516,
                                  32331, 34253, 36290, 38448, 40734, 43155};
    int unsigned oct4_tab[12] = '{5715, 6055, 6415, 6796, 7200, 7629,
                                  8082, 8563, 9072, 9612, 10183, 10788};

    note_player #(.RELEASE_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .play(play), .beat(beat), .stop(stop),
        .note_valid(note_valid), .note(note), .duration(duration),
        .note_instrument(note_instrument), .note_ready(note_ready),
        .note_finished(note_finished), .busy(busy), .h_play_enable(h_play_enable),
        .h_step_size(h_step_size), .h_instrument(h_instrument), .h_note_done(h_note_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_step(input int n);
        int k;
        if (n == 0) return 0;
        k = n - 1;
        return int'(base_tab[k % 12]) / (1 << (5 - k / 12));
    endfunction

    // Reference model: a note lives for its beats, then RC muted cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_playing = 0; m_beats_left = 0; m_rel_left = 0; m_rest = 0;
            m_step = 0; m_inst = 0; e_fin = 0; e_play_en = 0;
        end else begin
            e_fin = 0;
            if (!m_playing && m_rel_left == 0) begin
                if (note_valid && play) begin
                    m_playing    = 1;
                    m_beats_left = (duration == 0) ? 1 : int'(duration);
                    m_rest       = (note == 0);
                    m_step       = ref_step(int'(note));
                    m_inst       = int'(note_instrument);
                end
            end else if (m_playing) begin
                if (stop || (beat && play && m_beats_left == 1)) begin
                    m_playing  = 0;
                    m_rel_left = RC;
                end else if (beat && play) begin
                    m_beats_left--;
                end
            end else begin
                m_rel_left--;
                if (m_rel_left == 0) e_fin = 1;
            end
            e_play_en = (m_playing || m_rel_left != 0) && play;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit e_busy;
            e_busy = m_playing || m_rel_left != 0;
            check("busy", busy, e_busy);
            check("note_ready", note_ready, !e_busy && play);
            check("note_finished", note_finished, e_fin);
            check("h_play_enable", h_play_enable, e_play_en);
            check("h_note_done", h_note_done, !(m_playing && !m_rest));
            check("h_step_size", h_step_size, e_busy ? m_step : 0);
            check("h_instrument", h_instrument, m_inst);
            if (note_finished) fin_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_mode) begin
            beat = ($urandom_range(0, 2) == 0);
            stop = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) play = !play;
            note_valid      = $urandom_range(0, 1);
            note            = 6'($urandom_range(0, 63));
            duration        = 6'($urandom_range(0, 7));
            note_instrument = 2'($urandom_range(0, 3));
        end else begin
            stop = 1'b0;
            beat = beat_auto && (beat_ctr % beat_period == 0);
        end
        beat_ctr++;
    endtask

    task automatic send(input int n, input int d, input int inst);
        bit acc;
        note = 6'(n); duration = 6'(d); note_instrument = 2'(inst);
        note_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 1000 && !acc; i++) begin
            acc = note_ready;
            tick();
        end
        note_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (!busy) done = 1;
            else tick();
        end
        if (!done) check("idle_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int f0;
        #1 reset = 1'b1;
        cmp_en = 1;
        play = 1'b1;
        repeat (3) tick();
        check("reset_note_done", h_note_done, 1);
        check("reset_ready", note_ready, 1);
        reset = 1'b0;
        tick();

        // A4, two beats
        f0 = fin_seen;
        send(46, 2, 1);
        check("a4_step", h_step_size, 9612);
        check("a4_inst", h_instrument, 1);
        check("a4_done", h_note_done, 0);
        wait_idle();
        check("a4_finished", fin_seen - f0, 1);

        // C4..B4, one beat each
        f0 = fin_seen;
        for (int i = 0; i < 12; i++) begin
            send(37 + i, 1, i % 4);
            check("octave4_step", h_step_size, oct4_tab[i]);
            wait_idle();
        end
        check("octave4_finished", fin_seen - f0, 12);

        // rest
        send(0, 3, 2);
        check("rest_step", h_step_size, 0);
        check("rest_done", h_note_done, 1);
        wait_idle();

        // pause mid-note
        send(40, 4, 0);
        tick(); tick();
        play = 1'b0;
        repeat (2) tick();
        check("pause_play_en", h_play_enable, 0);
        repeat (18) tick();
        check("pause_busy", busy, 1);
        play = 1'b1;
        wait_idle();

        // stop right after accept
        beat_auto = 0;
        f0 = fin_seen;
        send(20, 10, 3);
        stop = 1'b1;
        tick();
        check("stop_busy", busy, 1);
        check("stop_muted", h_note_done, 1);
        wait_idle();
        check("stop_finished", fin_seen - f0, 1);

        // stop coincident with terminal beat
        f0 = fin_seen;
        send(50, 1, 2);
        beat = 1'b1; stop = 1'b1;
        wait_idle();
        repeat (RC + 2) tick();
        check("stop_beat_finished", fin_seen - f0, 1);

        // asynchronous reset mid-note
        beat_auto = 1;
        send(30, 10, 3);
        repeat (3) tick();
        #1 reset = 1'b1;
        #1;
        check("rst_play_en", h_play_enable, 0);
        check("rst_done", h_note_done, 1);
        check("rst_step", h_step_size, 0);
        check("rst_inst", h_instrument, 0);
        check("rst_busy", busy, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // duration 0 behaves as 1
        f0 = fin_seen;
        send(10, 0, 1);
        check("dur0_step", h_step_size, ref_step(10));
        wait_idle();
        check("dur0_finished", fin_seen - f0, 1);

        // random traffic
        rand_mode = 1;
        repeat (3000) tick();
        rand_mode = 0;
        note_valid = 1'b0;
        play = 1'b1;
        wait_idle();
        check("random_ready", note_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_player.md
# note_player

Sequencing controller for the harmonics synthesis engine. It accepts note requests (note code, duration in beats, instrument) over a valid/ready handshake and converts the note code to a 20-bit phase step. It then drives the engine's play_enable, step_size, instrument and note_done controls for the note's duration, followed by a short muted release gap. It sits between the song/score reader and the harmonics engine, so the engine never sees a mid-note change of step size or instrument.

## Interface
Parameters:
- RELEASE_CYCLES, 4: clock cycles the engine is held muted after each note (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  global run enable; low pauses beat counting and disables the engine
- beat  in  1  one-cycle pulse per beat, from the tempo divider
- stop  in  1  one-cycle abort of the current note
- note_valid  in  1  note request valid
- note  in  6  note code; 0 = rest, 1..63 = C1..D6 chromatic
- duration  in  6  length in beats; 0 is treated as 1
- note_instrument  in  2  instrument for this note
- note_ready  out  1  request accepted when note_valid && note_ready
- note_finished  out  1  one-cycle pulse when a note's release gap ends
- busy  out  1  high in PLAY or RELEASE
- h_play_enable  out  1  to engine play_enable
- h_step_size  out  20  to engine step_size
- h_instrument  out  2  to engine instrument
- h_note_done  out  1  to engine note_done (mute)

## Operation
- States: IDLE, PLAY, RELEASE.
- note_ready = (state==IDLE) && play. This is combinational from registered state.
- IDLE:
  - Outputs: h_play_enable=0, h_note_done=1, h_step_size=0; h_instrument holds its last value.
  - On accept: latch step, instrument, duration (0 becomes 1), rest flag; clear the beat counter; go to PLAY.
- Step conversion for note n≥1:
  - k=n-1; semitone=k mod 12; octave=k/12 (0..5).
  - step = BASE[semitone] >> (5-octave).
  - BASE = 22861, 24220, 25661, 27187, 28803, 30516, 32331, 34253, 36290, 38448, 40734, 43155.
  - n=0 (rest): step=0.
- PLAY:
  - Outputs: h_play_enable=play; h_note_done=rest flag; h_step_size and h_instrument are the latched values, constant for the whole note.
  - 6-bit beat counter increments on each cycle with beat && play.
  - When the increment reaches the latched duration, go to RELEASE on the next edge.
  - beat while play=0 is ignored.
- RELEASE:
  - Outputs: h_note_done=1; h_play_enable=play; step and instrument held.
  - Counts RELEASE_CYCLES clocks regardless of play, then returns to IDLE and pulses note_finished on that same transition edge.
- stop:
  - In PLAY, go to RELEASE next edge; the release gap still runs in full.
  - In RELEASE or IDLE, no effect.
  - stop has priority over a same-cycle terminal beat; only one RELEASE is entered.
- Handshake corner cases:
  - note_valid in IDLE with play=0 is not accepted.
  - A beat on the accept cycle is not counted.
- Reset mid-note: all state and outputs return to reset values immediately (asynchronous).

## Timing
- Reset values:
  - state=IDLE; note_finished=0, busy=0.
  - h_play_enable=0, h_note_done=1, h_step_size=0, h_instrument=0.
  - note_ready follows play.
- Accept at edge N:
  - PLAY from N+1; h_step_size, h_instrument valid from N+1.
  - h_play_enable=1 and h_note_done=0 (non-rest) from N+1.
- Terminal beat sampled at edge M: RELEASE from M+1.
- Return to IDLE at M+1+RELEASE_CYCLES, with note_finished high for that one cycle.
- note_ready is high again in the same cycle note_finished is high, so back-to-back notes lose no cycles beyond the release gap.
- All outputs except note_ready are registered.

## Test plan
- Reset, play=1, request note=46 (A4), duration=2, instrument=1: h_step_size=9612 and h_instrument=1 the cycle after accept. h_note_done=0 until 1 cycle after the 2nd beat. Then h_note_done=1 for 4 cycles, then one note_finished pulse.
- Sequence of 12 notes (C4..B4, codes 37..48), duration=1: each h_step_size equals BASE[i]>>2, e.g. code 37 gives 5715 and code 48 gives 10788. Exactly 12 note_finished pulses; note_ready low throughout PLAY/RELEASE.
- Rest note 0, duration=3: h_step_size=0 and h_note_done=1 for all 3 beats, then release, then note_finished.
- Pause: drop play for 5 beats mid-note with duration=4. Beats during the pause are not counted; h_play_enable=0 during the pause; the note ends after 4 counted beats.
- stop one cycle after accept with duration=10: RELEASE the next cycle, note_finished after 4 cycles, no beats counted. Also cover stop and terminal beat in the same cycle: exactly one note_finished.
- Assert reset mid-PLAY: outputs take reset values immediately. After release, a new request is accepted normally; duration=0 behaves as duration=1.
